// File: rtl/bcd_excess3_serial.sv
// Bit-serial BCD to Excess-3 converter, LSB first, NDIG digits per frame.
// Define BCD_ERR_CHECK_EN to compile in invalid-digit (10..15) detection on dig_err.
module bcd_excess3_serial #(
  parameter int NDIG = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic in_start,
  input  logic in_bit,
  output logic out_valid,
  output logic out_bit,
  output logic dig_done,
  output logic frame_done,
  output logic dig_err
);

  localparam int DW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [DW-1:0] DIG_LAST = DW'(NDIG - 1);

  logic [1:0]    bit_idx_q, bit_idx_d;
  logic [DW-1:0] dig_idx_q, dig_idx_d;
  logic          carry_q, carry_d;
  logic          out_valid_q, out_valid_d;
  logic          out_bit_q, out_bit_d;
  logic          dig_done_q, dig_done_d;
  logic          frame_done_q, frame_done_d;
  logic          dig_err_q, dig_err_d;

  logic [1:0]    eff_bit_s;
  logic [DW-1:0] eff_dig_s;
  logic          eff_carry_s;
  logic          k_s;
  logic          sum_s;
  logic          cout_s;
  logic          digit_bad_s;

`ifdef BCD_ERR_CHECK_EN
  // Bits 0..2 of the digit are held; bit 3 is taken live when the digit completes.
  logic [2:0] cap_q, cap_d;
`endif

  // Position/carry of the bit being accepted; in_start forces bit 0 of digit 0.
  always_comb begin
    eff_bit_s   = bit_idx_q;
    eff_dig_s   = dig_idx_q;
    eff_carry_s = carry_q;
    if (in_start) begin
      eff_bit_s = 2'd0;
      eff_dig_s = '0;
    end else begin
      eff_bit_s = bit_idx_q;
      eff_dig_s = dig_idx_q;
    end
    if (eff_bit_s == 2'd0) begin
      eff_carry_s = 1'b0;
    end else begin
      eff_carry_s = carry_q;
    end
    case (eff_bit_s)
      2'd0:    k_s = 1'b1;
      2'd1:    k_s = 1'b1;
      2'd2:    k_s = 1'b0;
      2'd3:    k_s = 1'b0;
      default: k_s = 1'b0;
    endcase
    sum_s  = in_bit ^ k_s ^ eff_carry_s;
    cout_s = (in_bit & k_s) | (in_bit & eff_carry_s) | (k_s & eff_carry_s);
  end

`ifdef BCD_ERR_CHECK_EN
  // Digit value > 9 once its top bit arrives.
  always_comb begin
    digit_bad_s = ({in_bit, cap_q} > 4'd9);
  end
`else
  // Detection compiled out.
  always_comb begin
    digit_bad_s = 1'b0;
  end
`endif

  // Next-state: advance only on in_valid; pulses default low.
  always_comb begin
    bit_idx_d    = bit_idx_q;
    dig_idx_d    = dig_idx_q;
    carry_d      = carry_q;
    out_valid_d  = 1'b0;
    out_bit_d    = out_bit_q;
    dig_done_d   = 1'b0;
    frame_done_d = 1'b0;
    dig_err_d    = 1'b0;
`ifdef BCD_ERR_CHECK_EN
    cap_d        = cap_q;
`endif
    if (in_valid) begin
      out_valid_d = 1'b1;
      out_bit_d   = sum_s;
      carry_d     = cout_s;
      bit_idx_d   = eff_bit_s + 2'd1;
`ifdef BCD_ERR_CHECK_EN
      if (eff_bit_s != 2'd3) begin
        cap_d[eff_bit_s] = in_bit;
      end else begin
        cap_d = cap_q;
      end
`endif
      if (eff_bit_s == 2'd3) begin
        dig_done_d = 1'b1;
        dig_err_d  = digit_bad_s;
        if (eff_dig_s == DIG_LAST) begin
          dig_idx_d    = '0;
          frame_done_d = 1'b1;
        end else begin
          dig_idx_d    = eff_dig_s + DW'(1);
          frame_done_d = 1'b0;
        end
      end else begin
        dig_idx_d = eff_dig_s;
      end
    end else begin
      out_valid_d = 1'b0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx_q    <= 2'd0;
      dig_idx_q    <= '0;
      carry_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      out_bit_q    <= 1'b0;
      dig_done_q   <= 1'b0;
      frame_done_q <= 1'b0;
      dig_err_q    <= 1'b0;
`ifdef BCD_ERR_CHECK_EN
      cap_q        <= 3'd0;
`endif
    end else begin
      bit_idx_q    <= bit_idx_d;
      dig_idx_q    <= dig_idx_d;
      carry_q      <= carry_d;
      out_valid_q  <= out_valid_d;
      out_bit_q    <= out_bit_d;
      dig_done_q   <= dig_done_d;
      frame_done_q <= frame_done_d;
      dig_err_q    <= dig_err_d;
`ifdef BCD_ERR_CHECK_EN
      cap_q        <= cap_d;
`endif
    end
  end

  assign out_valid  = out_valid_q;
  assign out_bit    = out_bit_q;
  assign dig_done   = dig_done_q;
  assign frame_done = frame_done_q;
  assign dig_err    = dig_err_q;

endmodule
